ring_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among NUM_REQ requesters.
- Priority is held in a one-hot ring pointer that rotates left or right, using the same ring-counter convention as the design's shift ring counters.
- Sits between the requesting blocks and the shared resource; drives the one-hot grant vector and an encoded owner ID.

---
 rtl/ring_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_ring_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer, one-hot grant and encoded owner ID.
// Optional: define RING_ARB_IDLE_ROTATE_EN to rotate the pointer every idle cycle while nothing requests.
module ring_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 15,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock0,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               lr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [NUM_REQ-1:0] ptr
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] PTR_RST   = {1'b1, {(NUM_REQ-1){1'b0}}};
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);

  // Handshake: a requester holds req high until served; gnt rises the cycle after
  // req is sampled and stays until done, req drop or MAX_HOLD, then gnt is low for
  // at least one cycle before any new grant.
  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ID_W-1:0]   ptr_idx;
  logic [ID_W-1:0]   scan_pick;
  logic              scan_found;
  logic [ID_W-1:0]   rel_idx;
  logic              rel_done;
  logic              rel_drop;
  logic              rel_hold;
  int                pos;

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  assign ptr_idx = onehot_to_idx(ptr);

  // First set request starting at the pointer, walking in direction lr with wrap.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = '0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (lr) pos = (int'(ptr_idx) + k) % NUM_REQ;
      else    pos = (int'(ptr_idx) - k + NUM_REQ) % NUM_REQ;
      if (!scan_found && req[ID_W'(pos)]) begin
        scan_found = 1'b1;
        scan_pick  = ID_W'(pos);
      end
    end
  end

  assign rel_idx = lr ? ((gnt_id == ID_LAST) ? '0 : gnt_id + ID_W'(1))
                      : ((gnt_id == '0) ? ID_LAST : gnt_id - ID_W'(1));

  assign rel_done = done;
  assign rel_drop = ~req[gnt_id];
  assign rel_hold = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clock0) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_found) begin
            state    <= GRANT;
            gnt      <= ONE_HOT0 << scan_pick;
            gnt_id   <= scan_pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
`ifdef RING_ARB_IDLE_ROTATE_EN
            if (lr) ptr <= {ptr[NUM_REQ-2:0], ptr[NUM_REQ-1]};
            else    ptr <= {ptr[0], ptr[NUM_REQ-1:1]};
`else
            ptr <= ptr;
`endif
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_hold) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            ptr     <= ONE_HOT0 << rel_idx;
            timeout <= !rel_done && !rel_drop;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios plus random traffic against an index-level model.
module tb_ring_rr_arbiter;

  localparam int NUM_REQ  = 8;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = $clog2(NUM_REQ);

  logic               clock0 = 1'b0;
  logic               reset  = 1'b0;
  logic [NUM_REQ-1:0] req    = '0;
  logic               done   = 1'b0;
  logic               lr     = 1'b1;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               timeout;
  logic [NUM_REQ-1:0] ptr;

  int n_checks = 0;
  int n_fail   = 0;

  ring_rr_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clock0(clock0), .reset(reset), .req(req), .done(done), .lr(lr),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout), .ptr(ptr)
  );

  // clock/reset block
  always #5 clock0 = ~clock0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = idle), priority index, cycles granted so far.
  int m_owner   = -1;
  int m_ptr     = NUM_REQ - 1;
  int m_cnt     = 0;
  bit m_to      = 1'b0;
  bit model_on  = 1'b0;

  function automatic int first_req(input int start, input logic dir, input logic [NUM_REQ-1:0] r);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = dir ? (start + k) % NUM_REQ : (start - k + NUM_REQ) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clock0) begin
    if (!reset) begin
      m_owner = -1; m_ptr = NUM_REQ - 1; m_cnt = 0; m_to = 1'b0; model_on = 1'b1;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (req != 0) begin
        m_owner = first_req(m_ptr, lr, req);
        m_cnt   = 1;
      end else begin
`ifdef RING_ARB_IDLE_ROTATE_EN
        m_ptr = lr ? (m_ptr + 1) % NUM_REQ : (m_ptr + NUM_REQ - 1) % NUM_REQ;
`endif
      end
    end else begin
      m_to = 1'b0;
      if (done || !req[m_owner] || m_cnt == MAX_HOLD) begin
        m_to    = !done && req[m_owner];
        m_ptr   = lr ? (m_owner + 1) % NUM_REQ : (m_owner + NUM_REQ - 1) % NUM_REQ;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  end

  // Scoreboard compare on every falling edge once the model has seen a reset.
  always @(negedge clock0) begin
    if (model_on) begin
      check("gnt",     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("gnt_id",  32'(gnt_id),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check("busy",    32'(busy),    32'(m_owner >= 0));
      check("timeout", 32'(timeout), 32'(m_to));
      check("ptr",     32'(ptr),     32'd1 << m_ptr);
    end
  end

  // driver tasks: inputs only change just after a falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock0);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; done = 1'b0;
    step(2);
  endtask

  initial begin
    // Scenario 1: lr=1, MSB priority first, then wrap to 0
    lr = 1'b1;
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_ptr", 32'(ptr), 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1; req = 8'h81;
    step(1);
    check("s1_gnt", 32'(gnt), 32'h80);
    check("s1_id", 32'(gnt_id), 32'd7);
    done = 1'b1; req = 8'h01;
    step(1);
    done = 1'b0;
    check("s1_rel_gnt", 32'(gnt), 32'h00);
    check("s1_rel_ptr", 32'(ptr), 32'h01);
    step(1);
    check("s1_gnt2", 32'(gnt), 32'h01);
    check("s1_id2", 32'(gnt_id), 32'd0);
    done = 1'b1; req = '0;
    step(1);
    done = 1'b0;
    check("s1_ptr2", 32'(ptr), 32'h02);

    // Scenario 2: lr=0 scans downward
    lr = 1'b0;
    do_reset();
    reset = 1'b1; req = 8'h41;
    step(1);
    check("s2_gnt", 32'(gnt), 32'h40);
    done = 1'b1; req = 8'h01;
    step(1);
    done = 1'b0;
    check("s2_ptr", 32'(ptr), 32'h20);
    step(1);
    check("s2_gnt2", 32'(gnt), 32'h01);
    done = 1'b1; req = '0;
    step(1);
    done = 1'b0;
    check("s2_wrap_ptr", 32'(ptr), 32'h80);

    // Scenario 3: MAX_HOLD timeout and regrant, then owner drops req
    lr = 1'b1;
    do_reset();
    reset = 1'b1; req = 8'h04;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(1);
      check("s3_hold_gnt", 32'(gnt), 32'h04);
    end
    step(1);
    check("s3_to_gnt", 32'(gnt), 32'h00);
    check("s3_to_pulse", 32'(timeout), 32'd1);
    check("s3_to_ptr", 32'(ptr), 32'h08);
    step(1);
    check("s3_regrant", 32'(gnt), 32'h04);
    check("s3_to_clear", 32'(timeout), 32'd0);
    req = '0;
    step(1);
    check("s3_drop_gnt", 32'(gnt), 32'h00);
    check("s3_drop_to", 32'(timeout), 32'd0);
    check("s3_drop_ptr", 32'(ptr), 32'h08);

    // Scenario 4: reset during a grant, done in idle
    do_reset();
    reset = 1'b1; req = 8'h10;
    step(1);
    check("s4_gnt", 32'(gnt), 32'h10);
    reset = 1'b0;
    step(1);
    check("s4_rst_gnt", 32'(gnt), 32'h00);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_ptr", 32'(ptr), 32'h80);
    reset = 1'b1; req = '0; done = 1'b1;
    step(1);
    done = 1'b0;
    check("s4_idle_done", 32'(gnt), 32'h00);

    // Scenario 5: idle pointer behaviour
    lr = 1'b1;
    do_reset();
    reset = 1'b1;
    step(1);
`ifdef RING_ARB_IDLE_ROTATE_EN
    check("s5_ptr1", 32'(ptr), 32'h01);
    step(1);
    check("s5_ptr2", 32'(ptr), 32'h02);
    step(1);
    check("s5_ptr3", 32'(ptr), 32'h04);
    req = 8'hFF;
    step(1);
    check("s5_gnt", 32'(gnt), 32'h04);
`else
    check("s5_ptr1", 32'(ptr), 32'h80);
    step(2);
    check("s5_ptr3", 32'(ptr), 32'h80);
    req = 8'hFF;
    step(1);
    check("s5_gnt", 32'(gnt), 32'h80);
`endif

    // Random traffic: requests, done pulses, direction flips, rare resets
    req = '0; done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) req = '0;
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lr = ~lr;
    end
    reset = 1'b1; req = '0; done = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
